// File: rtl/regdst_scoreboard.sv
// Destination-register scoreboard: tracks in-flight producers per register with
// a countdown until their result is forwardable, and raises D-stage stalls.
module regdst_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int TW   = 2,
  parameter int TAGW = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            iss_valid,
  input  logic [3:0]      iss_regdst,
  input  logic [AW-1:0]   iss_dst,
  input  logic [TW-1:0]   iss_tnew,
  output logic [TAGW-1:0] iss_tag,
  input  logic [AW-1:0]   rs_addr,
  input  logic [AW-1:0]   rt_addr,
  input  logic [TW-1:0]   rs_tuse,
  input  logic [TW-1:0]   rt_tuse,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_dst,
  input  logic [TAGW-1:0] wb_tag,
  input  logic            flush,
  output logic            stall,
  output logic            fwd_rs,
  output logic            fwd_rt,
  output logic [AW:0]     pend_cnt
);

  logic [NREG-1:1] pend_v, iss_dec, iss_hit, wb_clr;
  logic [TW-1:0]   tnew_v [NREG-1:1];
  logic [TAGW-1:0] tag_v  [NREG-1:1];

  logic [TAGW-1:0] tag_ctr_q, tag_ctr_d;
  logic [AW:0]     pend_cnt_q, pend_cnt_d;
  logic            issue_acc, cnt_inc, cnt_dec;
  logic            rs_pend, rt_pend;
  logic [TW-1:0]   rs_tnew, rt_tnew;

  // Source lookups read registered state only; register 0 never matches.
  always_comb begin
    rs_pend = 1'b0;
    rt_pend = 1'b0;
    rs_tnew = '0;
    rt_tnew = '0;
    for (int i = 1; i < NREG; i++) begin
      if (rs_addr == AW'(i)) begin
        rs_pend = pend_v[i];
        rs_tnew = tnew_v[i];
      end
      if (rt_addr == AW'(i)) begin
        rt_pend = pend_v[i];
        rt_tnew = tnew_v[i];
      end
    end
  end

  assign stall  = (rs_pend && (rs_tnew > rs_tuse)) || (rt_pend && (rt_tnew > rt_tuse));
  assign fwd_rs = rs_pend && (rs_tnew == '0);
  assign fwd_rt = rt_pend && (rt_tnew == '0);

  assign issue_acc = iss_valid && !stall && !flush && (iss_regdst <= 4'd3) && (|iss_dec);

  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_entry
      logic            pend_q, pend_d;
      logic [TW-1:0]   tnew_q, tnew_d;
      logic [TAGW-1:0] tag_q, tag_d;

      assign iss_dec[gi] = (iss_dst == AW'(gi));
      assign iss_hit[gi] = iss_dec[gi] && issue_acc;
      // Tag match keeps an older producer's writeback from clearing a newer one.
      assign wb_clr[gi]  = wb_valid && (wb_dst == AW'(gi)) && pend_q && (tag_q == wb_tag);
      assign pend_v[gi]  = pend_q;
      assign tnew_v[gi]  = tnew_q;
      assign tag_v[gi]   = tag_q;

      always_comb begin
        pend_d = pend_q;
        tnew_d = tnew_q;
        tag_d  = tag_q;
        if (flush) begin
          pend_d = 1'b0;
        end else if (iss_hit[gi]) begin
          pend_d = 1'b1;
          tnew_d = iss_tnew;
          tag_d  = tag_ctr_q;
        end else begin
          if (wb_clr[gi]) pend_d = 1'b0;
          if (pend_q && (tnew_q != '0)) tnew_d = tnew_q - 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (!reset) begin
          pend_q <= 1'b0;
          tnew_q <= '0;
          tag_q  <= '0;
        end else begin
          pend_q <= pend_d;
          tnew_q <= tnew_d;
          tag_q  <= tag_d;
        end
      end
    end
  endgenerate

  // An issue onto the register being retired replaces it, so that retire is not counted.
  assign cnt_inc = |(iss_hit & ~pend_v);
  assign cnt_dec = |(wb_clr & ~iss_hit);

  always_comb begin
    tag_ctr_d  = tag_ctr_q + TAGW'(issue_acc);
    pend_cnt_d = pend_cnt_q + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);
    if (flush) pend_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tag_ctr_q  <= '0;
      pend_cnt_q <= '0;
    end else begin
      tag_ctr_q  <= tag_ctr_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  assign iss_tag  = tag_ctr_q;
  assign pend_cnt = pend_cnt_q;

endmodule

// File: tb/tb_regdst_scoreboard.sv
// Directed bench for regdst_scoreboard: linear steps with hand-computed expectations.
module tb_regdst_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       iss_valid;
  logic [3:0] iss_regdst;
  logic [4:0] iss_dst;
  logic [1:0] iss_tnew;
  logic [2:0] iss_tag;
  logic [4:0] rs_addr, rt_addr;
  logic [1:0] rs_tuse, rt_tuse;
  logic       wb_valid;
  logic [4:0] wb_dst;
  logic [2:0] wb_tag;
  logic       flush;
  logic       stall, fwd_rs, fwd_rt;
  logic [5:0] pend_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regdst_scoreboard dut (
    .clk(clk), .reset(reset),
    .iss_valid(iss_valid), .iss_regdst(iss_regdst), .iss_dst(iss_dst),
    .iss_tnew(iss_tnew), .iss_tag(iss_tag),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_tuse(rs_tuse), .rt_tuse(rt_tuse),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_tag(wb_tag),
    .flush(flush), .stall(stall), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
    .pend_cnt(pend_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    iss_valid = 1'b0; iss_regdst = 4'd0; iss_dst = '0; iss_tnew = '0;
    rs_addr = '0; rt_addr = '0; rs_tuse = '0; rt_tuse = '0;
    wb_valid = 1'b0; wb_dst = '0; wb_tag = '0; flush = 1'b0;
  endtask

  // Advance one edge, then give inputs a settle point away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic issue(input logic [4:0] d, input logic [1:0] tn, input logic [3:0] rd);
    iss_valid = 1'b1; iss_dst = d; iss_tnew = tn; iss_regdst = rd;
  endtask

  task automatic wb(input logic [4:0] d, input logic [2:0] t);
    wb_valid = 1'b1; wb_dst = d; wb_tag = t;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    do_reset();
    #1;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_fwd", 32'({fwd_rs, fwd_rt}), 0);
    chk("rst_tag", 32'(iss_tag), 0);
    chk("rst_cnt", 32'(pend_cnt), 0);

    // Countdown to forwardable
    issue(5'd8, 2'd2, 4'd0);
    #1 chk("t1_tag", 32'(iss_tag), 0);
    step();
    rs_addr = 5'd8; rs_tuse = 2'd0; rt_addr = 5'd8; rt_tuse = 2'd2;
    #1;
    chk("t1_stall0", 32'(stall), 1);
    chk("t1_cnt", 32'(pend_cnt), 1);
    chk("t1_fwdrt0", 32'(fwd_rt), 0);
    step();
    rs_addr = 5'd8; rs_tuse = 2'd0;
    #1 chk("t1_stall1", 32'(stall), 1);
    step();
    rs_addr = 5'd8; rs_tuse = 2'd0;
    #1;
    chk("t1_stall2", 32'(stall), 0);
    chk("t1_fwd", 32'(fwd_rs), 1);
    step();
    rs_addr = 5'd8;
    #1 chk("t1_sat_fwd", 32'(fwd_rs), 1);
    wb(5'd8, 3'd0);
    step();
    rs_addr = 5'd8;
    #1;
    chk("t1_wb_fwd", 32'(fwd_rs), 0);
    chk("t1_wb_cnt", 32'(pend_cnt), 0);

    // Stale writeback must not clear newer producer
    do_reset();
    issue(5'd5, 2'd0, 4'd1);
    step();
    issue(5'd5, 2'd0, 4'd2);
    #1 chk("t2_tag1", 32'(iss_tag), 1);
    step();
    #1 chk("t2_cnt_ovw", 32'(pend_cnt), 1);
    wb(5'd5, 3'd0);
    step();
    rs_addr = 5'd5;
    #1;
    chk("t2_stale_fwd", 32'(fwd_rs), 1);
    chk("t2_stale_cnt", 32'(pend_cnt), 1);
    wb(5'd5, 3'd1);
    step();
    rs_addr = 5'd5;
    #1;
    chk("t2_clr_fwd", 32'(fwd_rs), 0);
    chk("t2_clr_cnt", 32'(pend_cnt), 0);

    // Non-writing regdst, dst 0, and issue blocked by stall (tag_ctr is 2 here)
    issue(5'd6, 2'd3, 4'd4);
    step();
    issue(5'd0, 2'd3, 4'd0);
    step();
    rs_addr = 5'd6; rt_addr = 5'd0;
    #1;
    chk("t3_tag", 32'(iss_tag), 2);
    chk("t3_cnt", 32'(pend_cnt), 0);
    chk("t3_stall", 32'(stall), 0);
    chk("t3_fwd", 32'({fwd_rs, fwd_rt}), 0);
    issue(5'd6, 2'd3, 4'd3);
    step();
    issue(5'd10, 2'd1, 4'd0);
    rs_addr = 5'd6; rs_tuse = 2'd0;
    #1;
    chk("t3_stall_b", 32'(stall), 1);
    chk("t3_tag_b", 32'(iss_tag), 3);
    step();
    rs_addr = 5'd10;
    #1;
    chk("t3_blk_tag", 32'(iss_tag), 3);
    chk("t3_blk_cnt", 32'(pend_cnt), 1);
    chk("t3_blk_fwd", 32'(fwd_rs), 0);

    // Flush beats a same-cycle issue; tag_ctr survives flush
    do_reset();
    issue(5'd3, 2'd3, 4'd0); step();
    issue(5'd4, 2'd3, 4'd0); step();
    issue(5'd7, 2'd3, 4'd0); step();
    #1 chk("t4_cnt3", 32'(pend_cnt), 3);
    issue(5'd9, 2'd0, 4'd0);
    flush = 1'b1;
    step();
    rs_addr = 5'd9; rt_addr = 5'd3;
    #1;
    chk("t4_cnt", 32'(pend_cnt), 0);
    chk("t4_tag", 32'(iss_tag), 3);
    chk("t4_fwd9", 32'(fwd_rs), 0);
    chk("t4_stall", 32'(stall), 0);

    // Tag wrap over nine issues to regs 1..9
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      issue(5'(i), 2'd0, 4'd0);
      #1 chk("t5_tag", 32'(iss_tag), 32'((i - 1) % 8));
      step();
    end
    #1;
    chk("t5_tag_end", 32'(iss_tag), 1);
    chk("t5_cnt", 32'(pend_cnt), 9);
    wb(5'd9, 3'd0);
    step();
    rs_addr = 5'd9; rt_addr = 5'd1;
    #1;
    chk("t5_wrap_clr", 32'(fwd_rs), 0);
    chk("t5_reg1_kept", 32'(fwd_rt), 1);
    chk("t5_cnt8", 32'(pend_cnt), 8);
    wb(5'd2, 3'd0);
    step();
    rs_addr = 5'd2;
    #1;
    chk("t5_mis_fwd", 32'(fwd_rs), 1);
    chk("t5_mis_cnt", 32'(pend_cnt), 8);

    // Same-cycle issue and matching wb on reg 12: issue wins
    issue(5'd12, 2'd0, 4'd0);
    step();
    #1 chk("t6_cnt9", 32'(pend_cnt), 9);
    issue(5'd12, 2'd2, 4'd0);
    wb(5'd12, 3'd1);
    step();
    rs_addr = 5'd12; rs_tuse = 2'd0;
    #1;
    chk("t6_cnt", 32'(pend_cnt), 9);
    chk("t6_stall", 32'(stall), 1);
    wb(5'd12, 3'd1);
    step();
    rt_addr = 5'd12; rt_tuse = 2'd0;
    #1 chk("t6_old_wb", 32'(stall), 1);
    wb(5'd12, 3'd2);
    step();
    #1 chk("t6_new_wb", 32'(pend_cnt), 8);

    // Reset beats everything mid-operation
    reset = 1'b0;
    issue(5'd13, 2'd3, 4'd0);
    flush = 1'b1;
    step();
    reset = 1'b1;
    rs_addr = 5'd2; rt_addr = 5'd13;
    #1;
    chk("t7_cnt", 32'(pend_cnt), 0);
    chk("t7_tag", 32'(iss_tag), 0);
    chk("t7_fwd", 32'({fwd_rs, fwd_rt}), 0);
    chk("t7_stall", 32'(stall), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
